// File: rtl/cpu_control_unit_pkg.sv
// cpu_control_unit_pkg: opcodes, instruction fields, FSM states and decode bundle of the 4-bit CPU
package cpu_control_unit_pkg;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_CMP = 4'h5;
    localparam logic [3:0] OP_ADC = 4'h6;
    localparam logic [3:0] OP_NOP = 4'h7;
    localparam logic [3:0] OP_LDI = 4'h8;
    localparam logic [3:0] OP_OUT = 4'h9;
    localparam logic [3:0] OP_JMP = 4'hA;
    localparam logic [3:0] OP_JZ  = 4'hB;
    localparam logic [3:0] OP_JC  = 4'hC;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 4;
    localparam int IMM_MSB = 3;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;

    typedef enum logic [1:0] {JC_ALWAYS, JC_ZERO, JC_CARRY} jcond_t;

    typedef struct packed {
        logic   is_alu;
        logic   writes_acc;
        logic   is_jump;
        jcond_t jump_cond;
        logic   is_out;
        logic   is_halt;
        logic   is_ldi;
    } dec_t;

endpackage

// File: rtl/cpu_control_unit_if.sv
// cpu_control_unit_if: ROM, ALU and output-port signals of the control unit
interface cpu_control_unit_if;
    logic [3:0] pc;
    logic [7:0] instr;
    logic [3:0] aluA;
    logic [3:0] aluB;
    logic [3:0] aluOpcode;
    logic       aluCin;
    logic [3:0] aluResult;
    logic       Zero;
    logic       Carry;
    logic [3:0] out_port;
    logic       out_valid;
    logic       halted;

    // aluCin carries the C flag into the ALU for ADC
    modport master (
        output pc, aluA, aluB, aluOpcode, aluCin, out_port, out_valid, halted,
        input  instr, aluResult, Zero, Carry
    );

    modport slave (
        input  pc, aluA, aluB, aluOpcode, aluCin, out_port, out_valid, halted,
        output instr, aluResult, Zero, Carry
    );
endinterface

// File: rtl/cpu_control_unit_instr_decode.sv
// cpu_instr_decode: combinational instruction classification from the IR
module cpu_instr_decode
    import cpu_control_unit_pkg::*;
(
    input  logic [7:0] ir_i,
    output dec_t       dec_o
);
    logic [3:0] op;
    logic       alu;
    logic       ldi;

    assign op  = ir_i[OPC_MSB:OPC_LSB];
    assign alu = op <= OP_ADC;
    assign ldi = op == OP_LDI;

    assign dec_o = '{
        is_alu:     alu,
        writes_acc: (alu && op != OP_CMP) || ldi,
        is_jump:    op == OP_JMP || op == OP_JZ || op == OP_JC,
        jump_cond:  op == OP_JZ ? JC_ZERO : op == OP_JC ? JC_CARRY : JC_ALWAYS,
        is_out:     op == OP_OUT,
        is_halt:    op == OP_HLT,
        is_ldi:     ldi
    };
endmodule

// File: rtl/cpu_control_unit.sv
// cpu_control_unit: multi-cycle FETCH/DECODE/EXEC/WB control FSM with PC, ACC and Z/C flags
// Optional CPU_SINGLE_STEP_EN adds a step input that gates each instruction fetch.
module cpu_control_unit
    import cpu_control_unit_pkg::*;
#(
    parameter logic [3:0] RESET_PC = 4'h0
) (
    input  logic               clock,
    input  logic               reset,
`ifdef CPU_SINGLE_STEP_EN
    input  logic               step,
`endif
    cpu_control_unit_if.master bus
);
    state_t     state_q, state_d;
    logic [7:0] ir_q, ir_d;
    logic [3:0] pc_q, pc_d;
    logic [3:0] acc_q, acc_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [3:0] op_q, op_d;
    logic [3:0] out_q, out_d;
    logic       z_q, z_d;
    logic       c_q, c_d;
    logic       ov_q, ov_d;
    logic [3:0] imm;
    logic       go;
    logic       take;
    dec_t       dec;

    cpu_instr_decode u_dec (
        .ir_i  (ir_q),
        .dec_o (dec)
    );

`ifdef CPU_SINGLE_STEP_EN
    assign go = step;
`else
    assign go = 1'b1;
`endif

    assign imm  = ir_q[IMM_MSB:IMM_LSB];
    assign take = dec.jump_cond == JC_ZERO ? z_q : dec.jump_cond == JC_CARRY ? c_q : 1'b1;

    // next state and architectural updates; everything holds unless a state changes it
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        pc_d    = pc_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        out_d   = out_q;
        z_d     = z_q;
        c_d     = c_q;
        ov_d    = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (go) begin
                    ir_d    = bus.instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec.is_alu) begin
                    a_d  = acc_q;
                    b_d  = imm;
                    op_d = ir_q[OPC_MSB:OPC_LSB];
                end
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (dec.is_alu) begin
                    state_d = S_WB;
                end else if (dec.is_halt) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_FETCH;
                    pc_d    = (dec.is_jump && take) ? imm : pc_q + 4'd1;
                    if (dec.is_ldi) acc_d = imm;
                    if (dec.is_out) begin
                        out_d = acc_q;
                        ov_d  = 1'b1;
                    end
                end
            end
            S_WB: begin
                if (dec.writes_acc) acc_d = bus.aluResult;
                z_d     = bus.Zero;
                c_d     = bus.Carry;
                pc_d    = pc_q + 4'd1;
                state_d = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // state and datapath registers; reset aborts any instruction in flight
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
            pc_q    <= RESET_PC;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            out_q   <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            pc_q    <= pc_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            out_q   <= out_d;
            z_q     <= z_d;
            c_q     <= c_d;
            ov_q    <= ov_d;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.aluA      = a_q;
    assign bus.aluB      = b_q;
    assign bus.aluOpcode = op_q;
    assign bus.aluCin    = c_q;
    assign bus.out_port  = out_q;
    assign bus.out_valid = ov_q;
    assign bus.halted    = state_q == S_HALT;
endmodule

// File: tb/tb_cpu_control_unit.sv
// tb_cpu_control_unit: directed ROM programs checked against an instruction-level CPU model
module tb_cpu_control_unit;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       step_v = 1'b1;
    logic [7:0] rom [16];
    logic [7:0] nr  [16];
    int         total = 0;
    int         bad = 0;
    int         ov_seen = 0;

    logic [3:0] m_pc, m_acc, m_a, m_b, m_op, m_out;
    logic [7:0] m_ir;
    logic       m_z, m_c, m_ov, m_halt;
    int         ph;

    cpu_control_unit_if bus ();

    cpu_control_unit #(.RESET_PC(4'h0)) dut (
        .clock (clock),
        .reset (reset),
`ifdef CPU_SINGLE_STEP_EN
        .step  (step_v),
`endif
        .bus   (bus)
    );

    always #5 clock = ~clock;

    assign bus.instr = rom[bus.pc];

    function automatic logic [5:0] alu_f(logic [3:0] a, logic [3:0] b, logic [3:0] op, logic ci);
        logic [4:0] s;
        case (op)
            4'd0:    s = {1'b0, a} + {1'b0, b};
            4'd1:    s = {1'b0, a} - {1'b0, b};
            4'd2:    s = {1'b0, a & b};
            4'd3:    s = {1'b0, a | b};
            4'd4:    s = {1'b0, a ^ b};
            4'd5:    s = {1'b0, a} - {1'b0, b};
            4'd6:    s = {1'b0, a} + {1'b0, b} + {4'd0, ci};
            default: s = 5'd0;
        endcase
        return {s[3:0] == 4'd0, s[4], s[3:0]};
    endfunction

    // registered ALU stand-in
    always @(posedge clock or posedge reset)
        if (reset) {bus.Zero, bus.Carry, bus.aluResult} <= 6'd0;
        else {bus.Zero, bus.Carry, bus.aluResult} <= alu_f(bus.aluA, bus.aluB, bus.aluOpcode, bus.aluCin);

    task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_pc = 4'h0; m_acc = 0; m_a = 0; m_b = 0; m_op = 0; m_out = 0;
        m_ir = 0; m_z = 0; m_c = 0; m_ov = 0; m_halt = 0; ph = 0;
    endtask

    // one clock of the ISA-level model: instructions take 3 cycles (4 for ALU ops)
    task automatic m_step();
        logic [3:0] opc, imm;
        int len, r;
        m_ov = 0;
        if (m_halt) return;
        if (ph == 0) begin
            if (!step_v) return;
            m_ir = rom[m_pc];
        end
        ph++;
        opc = m_ir[7:4];
        imm = m_ir[3:0];
        len = (opc <= 4'd6) ? 4 : 3;
        if (ph == 2 && opc <= 4'd6) begin
            m_a = m_acc; m_b = imm; m_op = opc;
        end
        if (ph < len) return;
        ph = 0;
        if (opc <= 4'd6) begin
            case (opc)
                4'd0:    r = int'(m_a) + int'(m_b);
                4'd2:    r = int'(m_a & m_b);
                4'd3:    r = int'(m_a | m_b);
                4'd4:    r = int'(m_a ^ m_b);
                4'd6:    r = int'(m_a) + int'(m_b) + int'(m_c);
                default: r = int'(m_a) - int'(m_b);
            endcase
            if (opc != 4'd5) m_acc = r[3:0];
            m_z  = r[3:0] == 4'd0;
            m_c  = (r > 15) || (r < 0);
            m_pc = m_pc + 4'd1;
        end else begin
            case (opc)
                4'h8: begin m_acc = imm; m_pc = m_pc + 4'd1; end
                4'h9: begin m_out = m_acc; m_ov = 1; m_pc = m_pc + 4'd1; end
                4'hA: m_pc = imm;
                4'hB: m_pc = m_z ? imm : m_pc + 4'd1;
                4'hC: m_pc = m_c ? imm : m_pc + 4'd1;
                4'hF: m_halt = 1;
                default: m_pc = m_pc + 4'd1;
            endcase
        end
    endtask

    // compare process: every falling edge, model versus DUT outputs
    initial forever begin
        @(negedge clock);
        if (reset) m_reset();
        else m_step();
        if (bus.out_valid === 1'b1) ov_seen++;
        chk("pc", bus.pc, m_pc);
        chk("aluA", bus.aluA, m_a);
        chk("aluB", bus.aluB, m_b);
        chk("aluOpcode", bus.aluOpcode, m_op);
        chk("out_port", bus.out_port, m_out);
        chk("out_valid", bus.out_valid, m_ov);
        chk("halted", bus.halted, m_halt);
    end

    task automatic clr();
        for (int i = 0; i < 16; i++) nr[i] = 8'hF0;
    endtask

    task automatic run(int n);
        @(negedge clock);
        #1 reset = 1'b1;
        for (int i = 0; i < 16; i++) rom[i] = nr[i];
        repeat (2) @(negedge clock);
        #1 reset = 1'b0;
        ov_seen = 0;
        repeat (n) @(negedge clock);
        #2;
    endtask

    initial begin
        clr();
        for (int i = 0; i < 16; i++) rom[i] = nr[i];
        // LDI 9, ADD 3, OUT
        clr(); nr[0] = 8'h89; nr[1] = 8'h03; nr[2] = 8'h90; run(16);
        chk("t1_out", bus.out_port, 8'hC);
        chk("t1_pulses", ov_seen[7:0], 8'd1);
        chk("t1_halt_pc", {bus.halted, bus.pc}, 8'h13);
        // 15+1 wraps, Z and C set, JZ and JC taken
        clr(); nr[0] = 8'h8F; nr[1] = 8'h01; nr[2] = 8'hB6; nr[6] = 8'h90; nr[7] = 8'hC9; run(25);
        chk("t2_acc0", bus.out_port, 8'h0);
        chk("t2_pc", bus.pc, 8'h9);
        clr(); nr[0] = 8'h8F; nr[1] = 8'h02; nr[2] = 8'hB6; run(16);
        chk("t2_jz_not_taken", bus.pc, 8'h3);
        // CMP keeps ACC; SUB borrow
        clr(); nr[0] = 8'h89; nr[1] = 8'h59; nr[2] = 8'hB5; nr[5] = 8'h90; run(20);
        chk("t3_cmp_acc", bus.out_port, 8'h9);
        chk("t3_cmp_pc", bus.pc, 8'h6);
        clr(); nr[0] = 8'h83; nr[1] = 8'h19; nr[2] = 8'h90; nr[3] = 8'hC5; run(20);
        chk("t3_sub", bus.out_port, 8'hA);
        chk("t3_borrow_jc", bus.pc, 8'h5);
        // ADC consumes carry from previous ADD
        clr(); nr[0] = 8'h8F; nr[1] = 8'h01; nr[2] = 8'hC4; nr[4] = 8'h60; nr[5] = 8'h90; nr[6] = 8'hC8; run(28);
        chk("t4_adc", bus.out_port, 8'h1);
        chk("t4_pc", bus.pc, 8'h7);
        // HLT at address 4 holds for 20 cycles
        clr(); nr[0] = 8'h70; nr[1] = 8'hD0; nr[2] = 8'hE0; nr[3] = 8'h70; run(35);
        chk("t5_halt", {bus.halted, bus.pc}, 8'h14);
        // reset during EXEC of ADD
        clr(); nr[0] = 8'h85; nr[1] = 8'h03; nr[2] = 8'h90; run(5);
        chk("t5_aluA_loaded", bus.aluA, 8'h5);
        reset = 1'b1;
        #1;
        chk("t5_rst_pc", bus.pc, 8'h0);
        chk("t5_rst_aluA", bus.aluA, 8'h0);
        clr(); nr[0] = 8'h90; run(10);
        chk("t5_acc_cleared", {bus.out_valid, bus.out_port}, 8'h0);
        chk("t5_pulse", ov_seen[7:0], 8'd1);
        // JMP F then NOP at F wraps pc to 0
        clr(); nr[0] = 8'hAF; nr[15] = 8'h70; run(3);
        chk("t6_jmp", bus.pc, 8'hF);
        repeat (3) @(negedge clock);
        #2;
        chk("t6_wrap", bus.pc, 8'h0);
`ifdef CPU_SINGLE_STEP_EN
        step_v = 1'b0;
        clr(); nr[0] = 8'h85; nr[1] = 8'h90; run(10);
        chk("ss_frozen", bus.pc, 8'h0);
        step_v = 1'b1;
        @(negedge clock);
        #1 step_v = 1'b0;
        repeat (8) @(negedge clock);
        #2;
        chk("ss_one", bus.pc, 8'h1);
        step_v = 1'b1;
`endif
        @(negedge clock);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
